// File: rtl/day022_prbs_checker.sv
// Receive-side checker for a 4-bit x^4+x^3+1 PRBS stream. It seeds from the incoming data,
// confirms lock after a run of matches, then flywheels and counts the mismatches it sees while locked.
module day022_prbs_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             valid_i,
    input  logic [3:0]       data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    function automatic logic [3:0] nxt(input logic [3:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

    state_t           state_reg, state_next;
    logic [3:0]       expected_reg, expected_next;
    logic [MW-1:0]    match_cnt_reg, match_cnt_next;
    logic [LW-1:0]    miss_cnt_reg, miss_cnt_next;
    logic             locked_reg, locked_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
    logic             count_err;
    logic [MW-1:0]    match_inc;
    logic [LW-1:0]    miss_inc;

    assign match_inc = match_cnt_reg + MW'(1);
    assign miss_inc  = miss_cnt_reg + LW'(1);

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_next       = 1'b0;
        count_err      = 1'b0;

        if (valid_i) begin
            case (state_reg)
                UNLOCKED: begin
                    // All-zero is the LFSR lock-up word and can never appear in a valid stream.
                    if (data_i != 4'h0) begin
                        expected_next  = nxt(data_i);
                        match_cnt_next = '0;
                        state_next     = LOCKING;
                    end
                end
                LOCKING: begin
                    if (data_i == expected_reg) begin
                        match_cnt_next = match_inc;
                        expected_next  = nxt(expected_reg);
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else if (data_i != 4'h0) begin
                        expected_next  = nxt(data_i);
                        match_cnt_next = '0;
                    end else begin
                        match_cnt_next = '0;
                        state_next     = UNLOCKED;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked the local generator free-runs and is never reseeded.
                    expected_next = nxt(expected_reg);
                    if (data_i != expected_reg) begin
                        err_next  = 1'b1;
                        count_err = 1'b1;
                        if (miss_inc == LW'(LOSS_COUNT)) begin
                            state_next     = UNLOCKED;
                            miss_cnt_next  = '0;
                            match_cnt_next = '0;
                        end else begin
                            miss_cnt_next = miss_inc;
                        end
                    end else begin
                        miss_cnt_next = '0;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end

        if (clear_i) begin
            err_cnt_next = CNT_W'(count_err);
        end else if (count_err && (err_cnt_reg != {CNT_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + CNT_W'(1);
        end else begin
            err_cnt_next = err_cnt_reg;
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_reg     <= UNLOCKED;
            expected_reg  <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            err_reg       <= err_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign locked_o  = locked_reg;
    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule

// File: doc/day022_prbs_checker.md
DAY022_PRBS_CHECKER -- requirements
Module: day022_prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4, SHALL set the consecutive matches after seeding required to declare lock.
REQ-002 Parameter LOSS_COUNT, default 3, SHALL set the consecutive mismatches while locked required to drop lock.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the error counter.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 n_rst_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 valid_i  input  1  SHALL qualify data_i; samples are taken only when high.
REQ-007 data_i  input  4  SHALL be the received sequence word, produced by the upstream 4-bit LFSR with polynomial x^4+x^3+1.
REQ-008 clear_i  input  1  SHALL be the synchronous clear of err_cnt_o.
REQ-009 locked_o  output  1  SHALL be high while the FSM is in LOCKED.
REQ-010 err_o  output  1  SHALL be a one-cycle pulse flagging a mismatch while locked.
REQ-011 err_cnt_o  output  CNT_W  SHALL be the saturating count of mismatches detected while locked.

Function
REQ-012 Next-value function SHALL be nxt(x) = {x[2:0], x[3]^x[2]}; from 4'hF the period-15 order is F,E,C,8,1,2,4,9,3,6,D,A,5,B,7,F.
REQ-013 FSM SHALL have three states: UNLOCKED, LOCKING, LOCKED; all outputs registered.
REQ-014 UNLOCKED with valid_i and data_i != 0: expected <= nxt(data_i), match count <= 0, go to LOCKING.
REQ-015 UNLOCKED with valid_i and data_i == 0 (LFSR lock-up value): stay UNLOCKED, no seeding.
REQ-016 LOCKING with valid_i and data_i == expected: match count increments, expected <= nxt(expected); on reaching LOCK_COUNT, go to LOCKED.
REQ-017 LOCKING with valid_i and data_i != expected: reseed per REQ-014/015 from data_i, match count <= 0; no err_o, no err_cnt_o change.
REQ-018 LOCKED with valid_i: expected <= nxt(expected) regardless of match (flywheel, never reseeded from data_i).
REQ-019 LOCKED mismatch: err_o high on the following cycle, err_cnt_o increments, miss count increments; reaching LOSS_COUNT goes to UNLOCKED.
REQ-020 LOCKED match: miss count <= 0, err_o low.
REQ-021 valid_i low: all state, expected and counters SHALL hold; err_o low.
REQ-022 err_cnt_o SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-023 clear_i and a counted mismatch in the same cycle: err_cnt_o SHALL become 1; clear_i alone: 0.
REQ-024 clear_i SHALL NOT affect FSM state, locked_o or err_o.
REQ-025 locked_o SHALL rise the cycle after the sample completing LOCK_COUNT matches and fall the cycle after the sample completing LOSS_COUNT misses.
REQ-026 The mismatch that drops lock SHALL still pulse err_o and be counted.

Reset
REQ-027 n_rst_i low SHALL immediately force UNLOCKED, locked_o=0, err_o=0, err_cnt_o=0, expected=0, match and miss counts=0.
REQ-028 Reset asserted mid-LOCKING or mid-LOCKED SHALL abandon lock; after release, reacquisition starts from REQ-014.
REQ-029 Deassertion SHALL take effect on the first clk_i edge after n_rst_i rises; no sample is taken while n_rst_i is low.

Verification
REQ-030 valid_i=1, data_i F,E,C,8,1 on consecutive cycles -> locked_o=1 the cycle after 1 is sampled; err_cnt_o=0.
REQ-031 Locked, then data_i 2,4,0 (expected 9),3 -> single err_o pulse after 0, err_cnt_o=1, locked_o stays 1.
REQ-032 Locked, then three consecutive wrong words -> three err_o pulses, err_cnt_o=3, locked_o=0 after third; correct sequence then relocks after 1+LOCK_COUNT samples.
REQ-033 data_i=0 repeatedly from reset -> locked_o stays 0, err_cnt_o stays 0; F,E,C,8 then 5 in LOCKING -> reseed from 5, no error counted.
REQ-034 CNT_W=2, inject 5 isolated errors while locked -> err_cnt_o saturates at 3; clear_i with simultaneous error -> 1.
REQ-035 valid_i toggling 1/0 over a correct sequence -> lock as in REQ-030, stretched; n_rst_i pulsed low mid-lock -> all outputs 0 asynchronously.
